// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package bus_arb_pkg;

    // Ownership state of the shared bus port.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    // Debug encoding on the owner output.
    localparam logic [1:0] OwnerIdle = 2'd0;
    localparam logic [1:0] OwnerM0   = 2'd1;
    localparam logic [1:0] OwnerM1   = 2'd2;

    // All-zero byte enables encode a read transfer.
    localparam logic [3:0] BYTEEN_READ = 4'b0000;

    function automatic logic is_read(input logic [3:0] byteen);
        return byteen == BYTEEN_READ;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the single data-bus port in front of the
// system bridge. Ownership is held for up to MAX_BURST granted transfers while
// the other master waits (unlimited while the owner holds lock), and read data
// is steered back to whichever master issued the read.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rdata,

    output logic [1:0]  owner
);

    localparam int unsigned    CntW    = $clog2(MAX_BURST) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Index of the master served most recently; 1 after reset so m0 wins the first tie.
    logic            last_q, last_d;
    logic            rd_pend_q, rd_pend_d;
    logic            rd_who_q, rd_who_d;

    logic gnt0, gnt1, any_gnt;
    logic at_limit;
    logic release0, release1;
    logic gnt_is_read;

    // Grants follow ownership combinationally: one transfer per granted cycle.
    always_comb begin
        gnt0     = (state_q == StOwn0) & m0_req;
        gnt1     = (state_q == StOwn1) & m1_req;
        any_gnt  = gnt0 | gnt1;
        at_limit = (cnt_q == CntLast);
        // Owner gives up the port when it stops requesting, or on its last
        // allowed unlocked transfer while the other master is waiting.
        release0 = ~m0_req | (gnt0 & ~m0_lock & m1_req & at_limit);
        release1 = ~m1_req | (gnt1 & ~m1_lock & m0_req & at_limit);
    end

    // Next-state, burst counter and round-robin pointer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (m0_req && m1_req) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (m0_req) begin
                    state_d = StOwn0;
                end else if (m1_req) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (release0) begin
                    state_d = m1_req ? StOwn1 : StIdle;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end else if (gnt0 && !at_limit) begin
                    // Saturates at the limit so a long lone burst never wraps.
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOwn1: begin
                if (release1) begin
                    state_d = m0_req ? StOwn0 : StIdle;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                end else if (gnt1 && !at_limit) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus mux: owner's address/data, byte enables only on a granted cycle.
    always_comb begin
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_byteen = BYTEEN_READ;
        owner      = OwnerIdle;
        unique case (state_q)
            StOwn0: begin
                bus_addr  = m0_addr;
                bus_wdata = m0_wdata;
                owner     = OwnerM0;
                if (gnt0) begin
                    bus_byteen = m0_byteen;
                end
            end
            StOwn1: begin
                bus_addr  = m1_addr;
                bus_wdata = m1_wdata;
                owner     = OwnerM1;
                if (gnt1) begin
                    bus_byteen = m1_byteen;
                end
            end
            default: begin
            end
        endcase
    end

    // Remember who issued a granted read; the bridge returns data next cycle.
    always_comb begin
        gnt_is_read = gnt1 ? is_read(m1_byteen) : is_read(m0_byteen);
        rd_pend_d   = any_gnt & gnt_is_read;
        rd_who_d    = any_gnt ? gnt1 : rd_who_q;
    end

    // Read return is steered by rd_who, independent of the current owner.
    always_comb begin
        m0_gnt    = gnt0;
        m1_gnt    = gnt1;
        m0_rvalid = rd_pend_q & ~rd_who_q;
        m1_rvalid = rd_pend_q & rd_who_q;
        m0_rdata  = m0_rvalid ? bus_rdata : '0;
        m1_rdata  = m1_rvalid ? bus_rdata : '0;
    end

    // State registers; reset drops any pending read return immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_who_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_who_q  <= rd_who_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a behavioural model.
module tb_bus_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byteen;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_byteen (m0_byteen),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_byteen (m1_byteen),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_byteen(bus_byteen),
        .bus_rdata (bus_rdata),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; m0_byteen = 4'hF;
        m1_addr = 32'h200; m1_wdata = 32'hCAFEF00D; m1_byteen = 4'h3;
        bus_rdata = 32'h0;
    endtask

    // Leaves the bench at posedge+1 of cycle 0 after reset release.
    task automatic do_reset();
        idle_inputs();
        m0_req = 1; m1_req = 1;
        reset = 1;
        @(negedge clk);
        chk("rst gnt0", {31'b0, m0_gnt}, 0);
        chk("rst gnt1", {31'b0, m1_gnt}, 0);
        chk("rst rvalid", {30'b0, m0_rvalid, m1_rvalid}, 0);
        chk("rst byteen", {28'b0, bus_byteen}, 0);
        chk("rst owner", {30'b0, owner}, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic r0, r1, l0, l1;
        logic [3:0]  be0, be1;
        logic [31:0] a0, rdata;
        logic g0, g1, rv0, rv1;
        logic [1:0]  own;
        logic [3:0]  be;
        logic [31:0] rd0;
    } vec_t;

    vec_t tbl [15];

    // ---------------- behavioural model ----------------
    int mdl_owner;   // 0 none, 1 master 0, 2 master 1
    int mdl_grants;  // transfers granted in the current tenure
    int mdl_last;    // master index served most recently
    bit mdl_pend;
    int mdl_who;

    task automatic model_reset();
        mdl_owner = 0; mdl_grants = 0; mdl_last = 1; mdl_pend = 0; mdl_who = 0;
    endtask

    // Called at negedge: compare the DUT to the model, then advance the model.
    task automatic model_cycle(input int cyc);
        bit rq[2], lk[2];
        bit g0e, g1e, rv0e, rv1e, done;
        int me, oth;
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        rq[0] = m0_req; rq[1] = m1_req; lk[0] = m0_lock; lk[1] = m1_lock;
        g0e = (mdl_owner == 1) && rq[0];
        g1e = (mdl_owner == 2) && rq[1];
        ea = (mdl_owner == 1) ? m0_addr : (mdl_owner == 2) ? m1_addr : 32'h0;
        ew = (mdl_owner == 1) ? m0_wdata : (mdl_owner == 2) ? m1_wdata : 32'h0;
        eb = g0e ? m0_byteen : g1e ? m1_byteen : 4'h0;
        rv0e = mdl_pend && (mdl_who == 0);
        rv1e = mdl_pend && (mdl_who == 1);
        chk($sformatf("rand[%0d] gnt0", cyc), {31'b0, m0_gnt}, {31'b0, g0e});
        chk($sformatf("rand[%0d] gnt1", cyc), {31'b0, m1_gnt}, {31'b0, g1e});
        chk($sformatf("rand[%0d] rvalid0", cyc), {31'b0, m0_rvalid}, {31'b0, rv0e});
        chk($sformatf("rand[%0d] rvalid1", cyc), {31'b0, m1_rvalid}, {31'b0, rv1e});
        chk($sformatf("rand[%0d] rdata0", cyc), m0_rdata, rv0e ? bus_rdata : 32'h0);
        chk($sformatf("rand[%0d] rdata1", cyc), m1_rdata, rv1e ? bus_rdata : 32'h0);
        chk($sformatf("rand[%0d] addr", cyc), bus_addr, ea);
        chk($sformatf("rand[%0d] wdata", cyc), bus_wdata, ew);
        chk($sformatf("rand[%0d] byteen", cyc), {28'b0, bus_byteen}, {28'b0, eb});
        chk($sformatf("rand[%0d] owner", cyc), {30'b0, owner}, mdl_owner);

        mdl_pend = (g0e && m0_byteen == 4'h0) || (g1e && m1_byteen == 4'h0);
        mdl_who  = g1e ? 1 : 0;
        if (mdl_owner == 0) begin
            mdl_grants = 0;
            if (rq[0] && rq[1]) mdl_owner = (mdl_last == 1) ? 1 : 2;
            else if (rq[0]) mdl_owner = 1;
            else if (rq[1]) mdl_owner = 2;
        end else begin
            me   = mdl_owner - 1;
            oth  = 1 - me;
            done = !rq[me] || (!lk[me] && rq[oth] && (mdl_grants + 1 >= MAXB));
            if (rq[me]) mdl_grants++;
            if (done) begin
                mdl_last   = me;
                mdl_owner  = rq[oth] ? oth + 1 : 0;
                mdl_grants = 0;
            end
        end
    endtask

    initial begin
        //        r0 r1 l0 l1 be0   be1   a0          rdata         g0 g1 rv0 rv1 own   be    rd0
        tbl[0]  = '{1, 0, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        0, 0, 0, 0, 2'd0, 4'h0, 32'h0};
        tbl[1]  = '{1, 0, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        1, 0, 0, 0, 2'd1, 4'hF, 32'h0};
        tbl[2]  = '{0, 0, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        0, 0, 0, 0, 2'd1, 4'h0, 32'h0};
        tbl[3]  = '{1, 0, 0, 0, 4'h0, 4'h3, 32'h7f00, 32'h0,        0, 0, 0, 0, 2'd0, 4'h0, 32'h0};
        tbl[4]  = '{1, 0, 0, 0, 4'h0, 4'h3, 32'h7f00, 32'h0,        1, 0, 0, 0, 2'd1, 4'h0, 32'h0};
        tbl[5]  = '{0, 1, 0, 0, 4'h0, 4'h3, 32'h7f00, 32'h12345678, 0, 0, 1, 0, 2'd1, 4'h0, 32'h12345678};
        tbl[6]  = '{0, 1, 0, 0, 4'h0, 4'h3, 32'h7f00, 32'h0,        0, 1, 0, 0, 2'd2, 4'h3, 32'h0};
        tbl[7]  = '{0, 0, 0, 0, 4'h0, 4'h3, 32'h7f00, 32'h0,        0, 0, 0, 0, 2'd2, 4'h0, 32'h0};
        tbl[8]  = '{1, 1, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        0, 0, 0, 0, 2'd0, 4'h0, 32'h0};
        tbl[9]  = '{1, 1, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        1, 0, 0, 0, 2'd1, 4'hF, 32'h0};
        tbl[10] = '{1, 1, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        1, 0, 0, 0, 2'd1, 4'hF, 32'h0};
        tbl[11] = '{0, 1, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        0, 0, 0, 0, 2'd1, 4'h0, 32'h0};
        tbl[12] = '{0, 1, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        0, 1, 0, 0, 2'd2, 4'h3, 32'h0};
        tbl[13] = '{0, 0, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        0, 0, 0, 0, 2'd2, 4'h0, 32'h0};
        tbl[14] = '{0, 0, 0, 0, 4'hF, 4'h3, 32'h100,  32'h0,        0, 0, 0, 0, 2'd0, 4'h0, 32'h0};

        // Directed table: write, read return across handover, dead-cycle handover.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            m0_req = tbl[i].r0; m1_req = tbl[i].r1;
            m0_lock = tbl[i].l0; m1_lock = tbl[i].l1;
            m0_byteen = tbl[i].be0; m1_byteen = tbl[i].be1;
            m0_addr = tbl[i].a0; bus_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("vec[%0d] gnt0", i), {31'b0, m0_gnt}, {31'b0, tbl[i].g0});
            chk($sformatf("vec[%0d] gnt1", i), {31'b0, m1_gnt}, {31'b0, tbl[i].g1});
            chk($sformatf("vec[%0d] rvalid0", i), {31'b0, m0_rvalid}, {31'b0, tbl[i].rv0});
            chk($sformatf("vec[%0d] rvalid1", i), {31'b0, m1_rvalid}, {31'b0, tbl[i].rv1});
            chk($sformatf("vec[%0d] owner", i), {30'b0, owner}, {30'b0, tbl[i].own});
            chk($sformatf("vec[%0d] byteen", i), {28'b0, bus_byteen}, {28'b0, tbl[i].be});
            chk($sformatf("vec[%0d] rdata0", i), m0_rdata, tbl[i].rd0);
            chk($sformatf("vec[%0d] rdata1", i), m1_rdata, 32'h0);
            chk($sformatf("vec[%0d] addr", i), bus_addr,
                (tbl[i].own == 2'd1) ? tbl[i].a0 : (tbl[i].own == 2'd2) ? 32'h200 : 32'h0);
            @(posedge clk); #1;
        end

        // Both masters requesting, locks low: 4-transfer bursts alternate.
        do_reset();
        m0_req = 1; m1_req = 1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            chk($sformatf("rr[%0d] gnt0", c), {31'b0, m0_gnt},
                {31'b0, ((c >= 1 && c <= 4) || (c >= 9 && c <= 12))});
            chk($sformatf("rr[%0d] gnt1", c), {31'b0, m1_gnt}, {31'b0, (c >= 5 && c <= 8)});
            @(posedge clk); #1;
        end

        // m1 holds lock past the burst limit, then releases after lock drops.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            m1_req  = 1;
            m0_req  = (c >= 1);
            m1_lock = (c >= 1 && c <= 9);
            @(negedge clk);
            chk($sformatf("lock[%0d] gnt1", c), {31'b0, m1_gnt}, {31'b0, (c >= 1 && c <= 10)});
            chk($sformatf("lock[%0d] gnt0", c), {31'b0, m0_gnt}, {31'b0, (c >= 11)});
            @(posedge clk); #1;
        end

        // Reset in the cycle after a granted read drops the read return.
        do_reset();
        m0_req = 1; m0_byteen = 4'h0; m0_addr = 32'h7f00;
        @(negedge clk);
        chk("rstrd c0 owner", {30'b0, owner}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstrd c1 gnt0", {31'b0, m0_gnt}, 1);
        @(posedge clk); #1;
        reset = 1; m0_req = 0; bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("rstrd c2 rvalid0", {31'b0, m0_rvalid}, 0);
        chk("rstrd c2 owner", {30'b0, owner}, 0);
        @(posedge clk); #1;
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstrd post[%0d] rvalid", c), {30'b0, m0_rvalid, m1_rvalid}, 0);
            chk($sformatf("rstrd post[%0d] owner", c), {30'b0, owner}, 0);
            @(posedge clk); #1;
        end
        m0_req = 1; m1_req = 1; m0_byteen = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstrd tie gnt0", {31'b0, m0_gnt}, 1);
        chk("rstrd tie gnt1", {31'b0, m1_gnt}, 0);
        @(posedge clk); #1;

        // Random traffic against the behavioural model.
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            m0_req    = ($urandom_range(99) < 75);
            m1_req    = ($urandom_range(99) < 75);
            m0_lock   = ($urandom_range(99) < 15);
            m1_lock   = ($urandom_range(99) < 15);
            m0_byteen = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            m1_byteen = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            m0_addr   = $urandom;
            m1_addr   = $urandom;
            m0_wdata  = $urandom;
            m1_wdata  = $urandom;
            bus_rdata = $urandom;
            @(negedge clk);
            model_cycle(i);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
